// File: rtl/crossbar_buffered.sv
// rtl/crossbar_buffered.sv - buffered crossbar with per-output FIFOs, valid/ready flow control and conflict resolution
module crossbar_buffered #(
    parameter int INPUT_NUM    = 5,
    parameter int OUTPUT_NUM   = 5,
    parameter int FLIT_SIZE    = 8,
    parameter int BUFFER_DEPTH = 2,
    localparam int SEL_SIZE    = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [INPUT_NUM*FLIT_SIZE-1:0]   data_i,
    input  logic [INPUT_NUM-1:0]             valid_i,
    output logic [INPUT_NUM-1:0]             ready_o,
    input  logic [OUTPUT_NUM*SEL_SIZE-1:0]   sel_i,
    input  logic [OUTPUT_NUM-1:0]            en_i,
    output logic [OUTPUT_NUM*FLIT_SIZE-1:0]  data_o,
    output logic [OUTPUT_NUM-1:0]            valid_o,
    input  logic [OUTPUT_NUM-1:0]            ready_i,
    output logic [OUTPUT_NUM-1:0]            conflict_o
);

    localparam int PTR_W   = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_W   = $clog2(BUFFER_DEPTH + 1);
    localparam int PAD_NUM = 1 << SEL_SIZE;
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BUFFER_DEPTH);
    localparam logic [SEL_SIZE:0] SEL_LIMIT = (SEL_SIZE + 1)'(INPUT_NUM);

    logic [FLIT_SIZE-1:0] mem    [OUTPUT_NUM][BUFFER_DEPTH];
    logic [PTR_W-1:0]     wr_ptr [OUTPUT_NUM];
    logic [PTR_W-1:0]     rd_ptr [OUTPUT_NUM];
    logic [CNT_W-1:0]     count  [OUTPUT_NUM];
    logic [OUTPUT_NUM-1:0] conflict_q;

    logic [SEL_SIZE-1:0]  sel  [OUTPUT_NUM];
    logic [FLIT_SIZE-1:0] flit [OUTPUT_NUM];
    logic [OUTPUT_NUM-1:0] req, winner, push, pop, space;
    logic [PAD_NUM-1:0]    valid_pad, claimed;

    // Pointers wrap at BUFFER_DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Decode each output's selected input, its flit and whether it is requesting.
    always_comb begin
        valid_pad = '0;
        valid_pad[INPUT_NUM-1:0] = valid_i;
        for (int j = 0; j < OUTPUT_NUM; j++) begin
            sel[j]  = sel_i[j*SEL_SIZE +: SEL_SIZE];
            flit[j] = '0;
            for (int i = 0; i < INPUT_NUM; i++) begin
                if (sel[j] == SEL_SIZE'(i)) begin
                    flit[j] = data_i[i*FLIT_SIZE +: FLIT_SIZE];
                end
            end
            space[j] = (count[j] < CNT_FULL);
            req[j]   = en_i[j] && ({1'b0, sel[j]} < SEL_LIMIT) && valid_pad[sel[j]];
        end
    end

    // Lowest-index requesting output claims an input; later requesters for it lose.
    always_comb begin
        claimed = '0;
        winner  = '0;
        for (int j = 0; j < OUTPUT_NUM; j++) begin
            if (req[j]) begin
                winner[j]         = !claimed[sel[j]];
                claimed[sel[j]]   = 1'b1;
            end
        end
    end

    // FIFO head presentation and push/pop qualification.
    always_comb begin
        data_o = '0;
        for (int j = 0; j < OUTPUT_NUM; j++) begin
            valid_o[j]                     = (count[j] != '0);
            data_o[j*FLIT_SIZE +: FLIT_SIZE] = mem[j][rd_ptr[j]];
        end
        push = req & winner & space;
        pop  = valid_o & ready_i;
    end

    // An input is consumed when the output that won it actually pushes.
    always_comb begin
        ready_o = '0;
        for (int i = 0; i < INPUT_NUM; i++) begin
            for (int j = 0; j < OUTPUT_NUM; j++) begin
                if (push[j] && (sel[j] == SEL_SIZE'(i))) begin
                    ready_o[i] = 1'b1;
                end
            end
        end
        if (!rst) begin
            ready_o = '0;
        end
    end

    // FIFO storage, pointers, occupancy and the registered conflict flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < OUTPUT_NUM; j++) begin
                wr_ptr[j] <= '0;
                rd_ptr[j] <= '0;
                count[j]  <= '0;
                for (int d = 0; d < BUFFER_DEPTH; d++) begin
                    mem[j][d] <= '0;
                end
            end
            conflict_q <= '0;
        end else begin
            for (int j = 0; j < OUTPUT_NUM; j++) begin
                if (push[j]) begin
                    mem[j][wr_ptr[j]] <= flit[j];
                    wr_ptr[j]         <= next_ptr(wr_ptr[j]);
                end
                if (pop[j]) begin
                    rd_ptr[j] <= next_ptr(rd_ptr[j]);
                end
                if (push[j] && !pop[j]) begin
                    count[j] <= count[j] + CNT_W'(1);
                end else if (!push[j] && pop[j]) begin
                    count[j] <= count[j] - CNT_W'(1);
                end
            end
            conflict_q <= req & ~winner;
        end
    end

    assign conflict_o = conflict_q;

endmodule

// File: tb/tb_crossbar_buffered.sv
// tb/tb_crossbar_buffered.sv - scoreboard bench for crossbar_buffered (depth 2 and depth 3 instances)
module tb_crossbar_buffered;

    localparam int NI = 5;
    localparam int NO = 5;
    localparam int FW = 8;
    localparam int SW = 3;

    logic clk, rst;

    // depth-2 instance
    logic [FW-1:0]    din  [NI];
    logic [SW-1:0]    sel  [NO];
    logic [NI*FW-1:0] data_i;
    logic [NO*SW-1:0] sel_i;
    logic [NI-1:0]    valid_i, ready_o;
    logic [NO-1:0]    en_i, valid_o, ready_i, conflict_o;
    logic [NO*FW-1:0] data_o;

    // depth-3 instance
    logic [FW-1:0]    din3 [NI];
    logic [SW-1:0]    sel3 [NO];
    logic [NI*FW-1:0] data3_i;
    logic [NO*SW-1:0] sel3_i;
    logic [NI-1:0]    valid3_i, ready3_o;
    logic [NO-1:0]    en3_i, valid3_o, ready3_i, conflict3_o;
    logic [NO*FW-1:0] data3_o;

    always_comb begin
        for (int k = 0; k < NI; k++) begin
            data_i[k*FW +: FW]  = din[k];
            data3_i[k*FW +: FW] = din3[k];
        end
        for (int j = 0; j < NO; j++) begin
            sel_i[j*SW +: SW]  = sel[j];
            sel3_i[j*SW +: SW] = sel3[j];
        end
    end

    crossbar_buffered #(.INPUT_NUM(NI), .OUTPUT_NUM(NO), .FLIT_SIZE(FW), .BUFFER_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .sel_i(sel_i), .en_i(en_i), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .conflict_o(conflict_o)
    );

    crossbar_buffered #(.INPUT_NUM(NI), .OUTPUT_NUM(NO), .FLIT_SIZE(FW), .BUFFER_DEPTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .data_i(data3_i), .valid_i(valid3_i), .ready_o(ready3_o),
        .sel_i(sel3_i), .en_i(en3_i), .data_o(data3_o), .valid_o(valid3_o),
        .ready_i(ready3_i), .conflict_o(conflict3_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [FW-1:0] exp_q [NO][$];
    logic [FW-1:0] exp3_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every presented head flit with the scoreboard, pop on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int j = 0; j < NO; j++) begin
                if (valid_o[j] === 1'b1) begin
                    if (exp_q[j].size() == 0) begin
                        chk($sformatf("unexpected_out%0d", j), {24'd0, data_o[j*FW +: FW]}, 32'hFFFF_FFFF);
                    end else begin
                        chk($sformatf("data_out%0d", j), {24'd0, data_o[j*FW +: FW]}, {24'd0, exp_q[j][0]});
                        if (ready_i[j]) void'(exp_q[j].pop_front());
                    end
                end
            end
            if (valid3_o[2] === 1'b1) begin
                if (exp3_q.size() == 0) begin
                    chk("unexpected_d3_out2", {24'd0, data3_o[2*FW +: FW]}, 32'hFFFF_FFFF);
                end else begin
                    chk("d3_data_out2", {24'd0, data3_o[2*FW +: FW]}, {24'd0, exp3_q[0]});
                    if (ready3_i[2]) void'(exp3_q.pop_front());
                end
            end
        end
    end

    initial begin
        int sent;
        int mcnt;
        logic acc, pp;

        // Reset with everything asserted.
        rst = 1'b0;
        en_i = '1; valid_i = '1; ready_i = '1;
        en3_i = '0; valid3_i = '0; ready3_i = '1;
        for (int k = 0; k < NI; k++) begin din[k] = 8'hA0 + 8'(k); din3[k] = '0; end
        for (int j = 0; j < NO; j++) begin sel[j] = 3'(4 - j); sel3[j] = '0; end
        repeat (2) begin
            step(); #2;
            chk("rst_ready", {27'd0, ready_o}, 32'd0);
            chk("rst_valid", {27'd0, valid_o}, 32'd0);
            chk("rst_data", {24'd0, data_o[7:0]} | {8'd0, data_o[39:16]}, 32'd0);
            chk("rst_conflict", {27'd0, conflict_o}, 32'd0);
        end
        step();
        rst = 1'b1; en_i = '0; valid_i = '0;
        mon_en = 1'b1;

        // Full permutation, sustained for 8 cycles.
        for (int c = 0; c < 8; c++) begin
            step();
            for (int k = 0; k < NI; k++) din[k] = 8'hA0 + 8'(k) + 8'(8 * c);
            en_i = '1; valid_i = '1;
            #2;
            chk($sformatf("perm_ready_c%0d", c), {27'd0, ready_o}, 32'h1F);
            for (int j = 0; j < NO; j++) exp_q[j].push_back(din[4 - j]);
            if (c == 1) chk("perm_valid", {27'd0, valid_o}, 32'h1F);
            if (c == 1) chk("perm_data0", {24'd0, data_o[7:0]}, 32'hA4);
        end
        step(); en_i = '0; valid_i = '0;
        step(); #2;
        chk("perm_drained", {27'd0, valid_o}, 32'd0);

        // Backpressure on output 0.
        step();
        ready_i = 5'b11110; sel[0] = 3'd1; en_i = 5'b00001; valid_i = 5'b00010; din[1] = 8'h11;
        #2; chk("bp_ready1", {27'd0, ready_o}, 32'h2); exp_q[0].push_back(8'h11);
        step(); din[1] = 8'h22;
        #2; chk("bp_ready2", {27'd0, ready_o}, 32'h2); exp_q[0].push_back(8'h22);
        step(); din[1] = 8'h33;
        #2; chk("bp_full_ready", {27'd0, ready_o}, 32'h0);
        chk("bp_head", {24'd0, data_o[7:0]}, 32'h11);
        step();
        #2; chk("bp_full_ready2", {27'd0, ready_o}, 32'h0);
        chk("bp_head_hold", {24'd0, data_o[7:0]}, 32'h11);
        step(); ready_i = '1; en_i = '0; valid_i = '0;
        step();
        step(); #2;
        chk("bp_drained", {31'd0, valid_o[0]}, 32'd0);

        // Conflict: outputs 1 and 3 both want input 2.
        step();
        sel[1] = 3'd2; sel[3] = 3'd2; en_i = 5'b01010; valid_i = 5'b00100; din[2] = 8'h5C;
        #2; chk("cf_ready", {27'd0, ready_o}, 32'h4); exp_q[1].push_back(8'h5C);
        step(); en_i = '0; valid_i = '0;
        #2; chk("cf_flag", {27'd0, conflict_o}, 32'h8);
        step();
        #2; chk("cf_clear", {27'd0, conflict_o}, 32'h0);

        // Out-of-range select is ignored.
        step();
        sel[0] = 3'd6; en_i = 5'b00001; valid_i = '1;
        #2; chk("oor_ready", {27'd0, ready_o}, 32'h0);
        step(); en_i = '0; valid_i = '0;
        #2; chk("oor_valid", {31'd0, valid_o[0]}, 32'd0);

        // Reset with two flits queued on output 0.
        step();
        ready_i = 5'b11110; sel[0] = 3'd0; en_i = 5'b00001; valid_i = 5'b00001; din[0] = 8'h71;
        #2; chk("mr_ready1", {27'd0, ready_o}, 32'h1); exp_q[0].push_back(8'h71);
        step(); din[0] = 8'h72;
        #2; chk("mr_ready2", {27'd0, ready_o}, 32'h1); exp_q[0].push_back(8'h72);
        step(); rst = 1'b0; din[0] = 8'h73; en_i = '1; valid_i = '1;
        #2; chk("mr_ready_in_rst", {27'd0, ready_o}, 32'h0);
        step(); rst = 1'b1; en_i = '0; valid_i = '0; ready_i = '1;
        #2; chk("mr_valid_after", {27'd0, valid_o}, 32'h0);
        chk("mr_data_after", {24'd0, data_o[7:0]}, 32'h0);
        exp_q[0].delete();
        step(); en_i = 5'b00001; valid_i = 5'b00001; din[0] = 8'h7E;
        #2; chk("mr_new_ready", {27'd0, ready_o}, 32'h1); exp_q[0].push_back(8'h7E);
        step(); en_i = '0; valid_i = '0;
        #2; chk("mr_new_head", {24'd0, data_o[7:0]}, 32'h7E);
        step();

        // Wrap-around on depth-3 output 2, flits 0x01..0x0A.
        sent = 0; mcnt = 0;
        sel3[2] = 3'd0; en3_i = 5'b00100;
        for (int c = 0; c < 80 && (sent < 10 || mcnt > 0); c++) begin
            step();
            valid3_i = (sent < 10) ? 5'b00001 : 5'b00000;
            din3[0] = 8'(sent + 1);
            ready3_i[2] = (c >= 4) && (c % 3 != 0);
            #2;
            acc = (sent < 10) && (mcnt < 3);
            pp  = (mcnt > 0) && ready3_i[2];
            chk($sformatf("wr_valid_c%0d", c), {31'd0, valid3_o[2]}, {31'd0, mcnt > 0});
            chk($sformatf("wr_ready_c%0d", c), {31'd0, ready3_o[0]}, {31'd0, acc});
            if (acc) begin exp3_q.push_back(din3[0]); sent++; end
            mcnt = mcnt + int'(acc) - int'(pp);
        end
        en3_i = '0; valid3_i = '0;
        chk("wr_all_sent", sent, 10);
        step(); step();

        for (int j = 0; j < NO; j++) chk($sformatf("sb_empty%0d", j), exp_q[j].size(), 0);
        chk("sb3_empty", exp3_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crossbar_buffered.md
# crossbar_buffered

Registered, flow-controlled successor to the combinational router crossbar. It sits between the switch allocator and the router output links. Each cycle it moves flits from the inputs selected by the allocator into a small per-output FIFO, and presents them downstream with valid/ready handshaking. It adds output buffering, per-input consume signalling, and detection and resolution of allocator conflicts, none of which the plain crossbar has.

## Interface
- INPUT_NUM, 5: number of input ports.
- OUTPUT_NUM, 5: number of output ports.
- FLIT_SIZE, 8: flit width in bits.
- BUFFER_DEPTH, 2: entries per output FIFO; legal values are ≥1.
- SEL_SIZE (localparam): $clog2(INPUT_NUM), minimum 1.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- data_i  in  [FLIT_SIZE-1:0] x INPUT_NUM  input flits.
- valid_i  in  1 x INPUT_NUM  input flit present.
- ready_o  out  1 x INPUT_NUM  input flit consumed this cycle (combinational).
- sel_i  in  [SEL_SIZE-1:0] x OUTPUT_NUM  input index routed to each output.
- en_i  in  1 x OUTPUT_NUM  allocator grant; the output's connection is active this cycle.
- data_o  out  [FLIT_SIZE-1:0] x OUTPUT_NUM  head flit of each output FIFO.
- valid_o  out  1 x OUTPUT_NUM  output FIFO non-empty.
- ready_i  in  1 x OUTPUT_NUM  downstream accepts the head flit.
- conflict_o  out  1 x OUTPUT_NUM  registered flag: this output lost an input conflict in the previous cycle.

## Operation
- Per output j, the block holds a circular FIFO with BUFFER_DEPTH entries, a write pointer, a read pointer and an occupancy count.
- The count is $clog2(BUFFER_DEPTH+1) bits wide. The pointers are max(1,$clog2(BUFFER_DEPTH)) bits wide and wrap from BUFFER_DEPTH-1 to 0. BUFFER_DEPTH does not need to be a power of two.
- space[j] = (count[j] < BUFFER_DEPTH), computed from registered state only.
- Request: req[j] = en_i[j] && valid_i[sel_i[j]] && sel_i[j] < INPUT_NUM. An out-of-range sel_i is ignored and nothing is written.
- Conflict resolution: if several requesting outputs select the same input, the lowest-index output wins. All other requesting outputs for that input lose.
- Push: push[j] = req[j] && winner[j] && space[j]. The FIFO writes data_i[sel_i[j]] at the write pointer.
- A losing output does not push. The allocator must re-grant it in a later cycle.
- ready_o[i] = OR over j of (push[j] && sel_i[j] == i). At most one output consumes a given input per cycle. An input is never duplicated (no multicast).
- Pop: pop[j] = valid_o[j] && ready_i[j]. The read pointer advances.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full: space[j] = 0, so the output does not push even when a pop occurs in the same cycle. With BUFFER_DEPTH=1 this limits throughput to 1 flit every 2 cycles. With BUFFER_DEPTH ≥ 2, sustained throughput is 1 flit per cycle.
- Empty: valid_o = 0, and ready_i is ignored.
- conflict_o[j] is set in the cycle after output j had req[j] && !winner[j], and clears otherwise. It is a diagnostic only and has no effect on data flow.
- Reset (rst == 0 at a clock edge), including mid-transfer:
  - all counts and pointers go to 0, and FIFO storage is cleared to 0;
  - valid_o = 0, data_o = 0, conflict_o = 0;
  - in-flight flits are discarded;
  - ready_o is forced to 0 while rst is low.

## Timing
- Latency: a flit consumed on edge N (ready_o high in cycle N) appears on data_o/valid_o in cycle N+1.
- data_o, valid_o and conflict_o are purely registered; there is no combinational path from inputs to these outputs.
- ready_o depends combinationally on en_i, sel_i and valid_i, plus registered counts. Upstream must sample ready_o in the same cycle it drives valid_i.
- Upstream flit hold rule: a flit stays in place until ready_o goes high. It is dropped only when ready_o was high.
- Downstream may hold ready_i low indefinitely. data_o is stable while valid_o && !ready_i.

## Test plan
- Reset: drive rst=0 for 2 cycles with en_i all 1 and valid_i all 1. Required: ready_o=0, valid_o=0, data_o=0 and conflict_o=0 throughout; no FIFO writes.
- Permutation, defaults: set sel_i={4,3,2,1,0}, en_i=5'b11111, data_i[k]=8'hA0+k, ready_i all 1. Required:
  - ready_o=all 1 in cycle N;
  - in cycle N+1, valid_o all 1 and data_o[j]=8'hA0+(4-j);
  - 1 flit per cycle sustained over 8 cycles.
- Backpressure with BUFFER_DEPTH=2: stream into output 0 with ready_i[0]=0. Required:
  - two flits accepted, then ready_o drops;
  - data_o[0] holds the first flit;
  - after ready_i[0]=1, both flits emerge in order, with no loss or duplication.
- Conflict: outputs 1 and 3 both select input 2 with en_i set, input 2 valid, data_i[2]=8'h5C. Required:
  - output 1 gets 8'h5C;
  - output 3 gets nothing;
  - conflict_o[3]=1 in the next cycle and conflict_o[1]=0.
- Wrap-around: BUFFER_DEPTH=3, interleave pushes and pops on output 2 for 10 flits (0x01..0x0A). Required: output order 0x01..0x0A, count never exceeds 3.
- Reset mid-operation: assert rst with two flits queued in output 0. Required: valid_o[0]=0 on the next cycle, and a new flit enqueued after reset emerges first.
